// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory subsystem: cache-line type and arbiter states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lc3b_types;

  // One cache line moved between caches and physical memory.
  typedef logic [127:0] lc3b_line;

  // Arbiter states: waiting for a request, or owning memory for one side.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Encoding of the last-granted side, used by round-robin arbitration.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line fills/writebacks onto one physical memory port.
// Latency: a request sampled in IDLE drives the memory strobe from the next cycle; resp is combinational from pmem_resp.
// Backpressure: the losing side simply waits with its request held; memory holds off via pmem_resp.
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   i_read, i_address, i_rdata, i_resp  instruction-cache fill interface
//   d_read, d_write, d_address, d_wdata,
//   d_rdata, d_resp                     data-cache fill/writeback interface
//   pmem_read, pmem_write, pmem_address,
//   pmem_wdata, pmem_rdata, pmem_resp   physical memory interface
module mem_arbiter
  import lc3b_types::*;
#(
  parameter bit RR_EN = 1'b0  // 0: data side always wins ties; 1: alternate on ties
) (
  input  logic            clk,
  input  logic            reset_n,
  // instruction cache
  input  logic            i_read,
  input  logic [15:0]     i_address,
  output lc3b_line        i_rdata,
  output logic            i_resp,
  // data cache
  input  logic            d_read,
  input  logic            d_write,
  input  logic [15:0]     d_address,
  input  lc3b_line        d_wdata,
  output lc3b_line        d_rdata,
  output logic            d_resp,
  // physical memory
  output logic            pmem_read,
  output logic            pmem_write,
  output logic [15:0]     pmem_address,
  output lc3b_line        pmem_wdata,
  input  lc3b_line        pmem_rdata,
  input  logic            pmem_resp
);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  logic        r_last_grant;
  logic [15:0] r_addr;
  lc3b_line    r_wdata;
  logic        r_write;

  logic        w_i_req;
  logic        w_d_req;
  logic        w_grant_i;
  logic        w_grant_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // Next-state and grant decision. Grants are only made from IDLE, which
  // guarantees one idle cycle between back-to-back transactions.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) begin
          // Tie: round-robin hands it to whichever side did not win last time.
          if (RR_EN && (r_last_grant == GRANT_D)) w_grant_i = 1'b1;
          else                                    w_grant_d = 1'b1;
        end else if (w_d_req) begin
          w_grant_d = 1'b1;
        end else if (w_i_req) begin
          w_grant_i = 1'b1;
        end
        if (w_grant_d)      w_next_state = SERVE_D;
        else if (w_grant_i) w_next_state = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State plus the transaction snapshot taken at grant. Memory sees only these
  // registers, so requester inputs may change freely during service.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_d) begin
        r_last_grant <= GRANT_D;
        r_addr       <= d_address;
        r_wdata      <= d_wdata;
        r_write      <= d_write;  // read+write together is treated as a writeback
      end else if (w_grant_i) begin
        r_last_grant <= GRANT_I;
        r_addr       <= i_address;
        r_wdata      <= d_wdata;
        r_write      <= 1'b0;
      end
    end
  end

  // Output decode. Strobes come from registered state only; resp is routed
  // combinationally to the owning side and is dead in IDLE.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    if (r_state != IDLE) begin
      pmem_read  = ~r_write;
      pmem_write = r_write;
    end
    if (r_state == SERVE_I) i_resp = pmem_resp;
    if (r_state == SERVE_D) d_resp = pmem_resp;
  end

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 uses fixed priority, instance 1 round-robin.
// Expected transactions are queued when requests are driven and popped when memory is strobed.
module tb_mem_arbiter;
  import lc3b_types::*;

  typedef struct packed {
    logic        side;   // 0 = I, 1 = D
    logic        wr;
    logic [15:0] addr;
    lc3b_line    wdata;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        i_read     [2];
  logic [15:0] i_address  [2];
  lc3b_line    i_rdata    [2];
  logic        i_resp     [2];
  logic        d_read     [2];
  logic        d_write    [2];
  logic [15:0] d_address  [2];
  lc3b_line    d_wdata    [2];
  lc3b_line    d_rdata    [2];
  logic        d_resp     [2];
  logic        pmem_read  [2];
  logic        pmem_write [2];
  logic [15:0] pmem_address [2];
  lc3b_line    pmem_wdata [2];
  lc3b_line    pmem_rdata [2];
  logic        pmem_resp  [2];

  int   n_checks;
  int   n_errors;
  exp_t sb0[$];
  exp_t sb1[$];

  mem_arbiter #(.RR_EN(1'b0)) u_fix (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read[0]), .i_address(i_address[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
    .d_read(d_read[0]), .d_write(d_write[0]), .d_address(d_address[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
    .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]), .pmem_address(pmem_address[0]),
    .pmem_wdata(pmem_wdata[0]), .pmem_rdata(pmem_rdata[0]), .pmem_resp(pmem_resp[0])
  );

  mem_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read[1]), .i_address(i_address[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
    .d_read(d_read[1]), .d_write(d_write[1]), .d_address(d_address[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
    .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]), .pmem_address(pmem_address[1]),
    .pmem_wdata(pmem_wdata[1]), .pmem_rdata(pmem_rdata[1]), .pmem_resp(pmem_resp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic side, input logic wr,
                      input logic [15:0] a, input lc3b_line w);
    exp_t e;
    e.side = side; e.wr = wr; e.addr = a; e.wdata = w;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Wait for the strobe, match it against the next expected transaction, hold
  // it for lat cycles, then answer with pmem_resp and confirm the idle gap.
  task automatic serve(input int k, input int lat, input int exp_lat, input bit disturb);
    exp_t     e;
    int       t;
    int       sz;
    lc3b_line rd;
    t = 0;
    while (!(pmem_read[k] || pmem_write[k]) && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    chk($sformatf("strobe_up[%0d]", k), 128'(pmem_read[k] | pmem_write[k]), 128'(1));
    if (exp_lat >= 0) chk($sformatf("grant_latency[%0d]", k), 128'(t), 128'(exp_lat));
    sz = (k == 0) ? sb0.size() : sb1.size();
    n_checks++;
    assert (sz > 0) else begin
      n_errors++;
      $error("FAIL sb_underflow[%0d]: observed %0d queued expected >0", k, sz);
    end
    if (sz == 0) return;
    e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
    for (int c = 0; c < lat; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      chk($sformatf("pmem_address[%0d]", k), 128'(pmem_address[k]), 128'(e.addr));
      chk($sformatf("pmem_write[%0d]", k), 128'(pmem_write[k]), 128'(e.wr));
      chk($sformatf("pmem_read[%0d]", k), 128'(pmem_read[k]), 128'(!e.wr));
      if (e.wr) chk($sformatf("pmem_wdata[%0d]", k), pmem_wdata[k], e.wdata);
      chk($sformatf("resp_early[%0d]", k), 128'({i_resp[k], d_resp[k]}), 128'(0));
      if (disturb) begin
        d_wdata[k]   = {$urandom, $urandom, $urandom, $urandom};
        d_address[k] = 16'($urandom);
        i_address[k] = 16'($urandom);
      end
    end
    @(negedge clk);
    rd = {$urandom, $urandom, $urandom, $urandom};
    pmem_rdata[k] = rd;
    pmem_resp[k]  = 1'b1;
    #1;
    chk($sformatf("i_resp[%0d]", k), 128'(i_resp[k]), 128'(!e.side));
    chk($sformatf("d_resp[%0d]", k), 128'(d_resp[k]), 128'(e.side));
    chk($sformatf("i_rdata[%0d]", k), i_rdata[k], rd);
    chk($sformatf("d_rdata[%0d]", k), d_rdata[k], rd);
    @(negedge clk);
    pmem_resp[k] = 1'b0;
    #1;
    chk($sformatf("idle_gap[%0d]", k), 128'({pmem_read[k], pmem_write[k]}), 128'(0));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b0; i_address[k] = '0;
      d_read[k] = 1'b0; d_write[k] = 1'b0; d_address[k] = '0; d_wdata[k] = '0;
      pmem_rdata[k] = '0; pmem_resp[k] = 1'b0;
    end

    // Reset state, and a request held during reset must not be granted.
    repeat (2) @(negedge clk);
    d_read[0] = 1'b1; d_address[0] = 16'h0A00;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_strobes[%0d]", k), 128'({pmem_read[k], pmem_write[k]}), 128'(0));
      chk($sformatf("rst_resps[%0d]", k), 128'({i_resp[k], d_resp[k]}), 128'(0));
      chk($sformatf("rst_addr[%0d]", k), 128'(pmem_address[k]), 128'(0));
      chk($sformatf("rst_wdata[%0d]", k), pmem_wdata[k], 128'(0));
    end
    @(negedge clk); #1;
    chk("rst_hold_no_grant", 128'({pmem_read[0], pmem_write[0]}), 128'(0));
    reset_n = 1'b1;
    push(0, 1'b1, 1'b0, 16'h0A00, '0);
    serve(0, 1, 1, 1'b0);
    d_read[0] = 1'b0;

    // Single instruction fill, memory answers after 3 cycles.
    i_read[0] = 1'b1; i_address[0] = 16'h1230;
    push(0, 1'b0, 1'b0, 16'h1230, '0);
    serve(0, 3, 1, 1'b0);
    i_read[0] = 1'b0;

    // A stray pmem_resp while idle produces no resp and no strobe.
    pmem_resp[0] = 1'b1;
    #1;
    chk("idle_resp_ignored", 128'({i_resp[0], d_resp[0]}), 128'(0));
    @(negedge clk); #1;
    chk("idle_resp_no_strobe", 128'({pmem_read[0], pmem_write[0]}), 128'(0));
    pmem_resp[0] = 1'b0;

    // Fixed priority: D wins every tie, I waits until D drops.
    i_read[0] = 1'b1; i_address[0] = 16'h1111;
    d_read[0] = 1'b1; d_address[0] = 16'h2222;
    for (int n = 0; n < 3; n++) push(0, 1'b1, 1'b0, 16'h2222, '0);
    for (int n = 0; n < 3; n++) serve(0, 2, 1, 1'b0);
    d_read[0] = 1'b0;
    push(0, 1'b0, 1'b0, 16'h1111, '0);
    serve(0, 2, 1, 1'b0);
    i_read[0] = 1'b0;

    // Writeback with read also high: treated as write; inputs scrambled mid-service.
    d_write[0] = 1'b1; d_read[0] = 1'b1; d_address[0] = 16'h4000;
    d_wdata[0] = {16{8'hA5}};
    push(0, 1'b1, 1'b1, 16'h4000, {16{8'hA5}});
    serve(0, 3, 1, 1'b1);
    d_write[0] = 1'b0; d_read[0] = 1'b0;

    // Requester drops right after grant; transaction still completes.
    i_read[0] = 1'b1; i_address[0] = 16'hBEEF;
    push(0, 1'b0, 1'b0, 16'hBEEF, '0);
    @(negedge clk); #1;
    i_read[0] = 1'b0;
    serve(0, 2, -1, 1'b0);

    // Round-robin: ties alternate starting with D.
    i_read[1] = 1'b1; i_address[1] = 16'h3330;
    d_read[1] = 1'b1; d_address[1] = 16'h7770;
    for (int n = 0; n < 2; n++) begin
      push(1, 1'b1, 1'b0, 16'h7770, '0);
      push(1, 1'b0, 1'b0, 16'h3330, '0);
    end
    for (int n = 0; n < 4; n++) serve(1, 2, 1, 1'b0);
    i_read[1] = 1'b0; d_read[1] = 1'b0;

    // Reset in the middle of a D service kills the strobe and resp at once.
    d_read[0] = 1'b1; d_address[0] = 16'h5000;
    @(negedge clk); #1;
    chk("pre_rst_strobe", 128'(pmem_read[0]), 128'(1));
    pmem_resp[0] = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_strobes", 128'({pmem_read[0], pmem_write[0]}), 128'(0));
    chk("async_rst_resps", 128'({i_resp[0], d_resp[0]}), 128'(0));
    chk("async_rst_addr", 128'(pmem_address[0]), 128'(0));
    @(negedge clk);
    reset_n = 1'b1; pmem_resp[0] = 1'b0; d_read[0] = 1'b0;
    i_read[0] = 1'b1; i_address[0] = 16'h6000;
    push(0, 1'b0, 1'b0, 16'h6000, '0);
    #1;
    serve(0, 2, 1, 1'b0);
    i_read[0] = 1'b0;

    chk("sb0_drained", 128'(sb0.size()), 128'(0));
    chk("sb1_drained", 128'(sb1.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
